// File: rtl/psum_acc_ctrl.sv
// Bit-serial partial-sum accumulator for a CIM macro: shifts and adds one
// bit-plane partial sum per accepted cycle, MSB plane first, then holds the result.
module psum_acc_ctrl #(
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               cfg_nbits,
  input  logic                     cfg_signed,
  input  logic                     psum_valid,
  input  logic signed [PSUM_W-1:0] psum_in,
  output logic                     psum_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [3:0]               nbits_q, nbits_d;
  logic                     sgn_q, sgn_d;
  logic                     ovf_q, ovf_d;

  logic signed [ACC_W-1:0]  shl, psum_ext, addend, sum;
  logic [4:0]               n_eff;
  logic                     sub, plane_acc, last_plane, shift_ovf, add_ovf;

  // Signed overflow of a + b: operands agree in sign but the result does not.
  function automatic logic add_overflow(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  assign plane_acc  = (state_q == S_ACC) && psum_valid;
  assign sub        = sgn_q && (cnt_q == 5'd0);
  assign n_eff      = (nbits_q == 4'd0) ? 5'd16 : {1'b0, nbits_q};
  assign last_plane = (cnt_q == n_eff - 5'd1);

  assign shl       = {acc_q[ACC_W-2:0], 1'b0};
  assign shift_ovf = acc_q[ACC_W-1] != acc_q[ACC_W-2];
  assign psum_ext  = {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
  // Negative-weight MSB plane reuses the one adder: invert operand, carry-in 1.
  assign addend    = sub ? ~psum_ext : psum_ext;
  assign sum       = shl + addend + {{(ACC_W-1){1'b0}}, sub};
  assign add_ovf   = add_overflow(shl[ACC_W-1], addend[ACC_W-1], sum[ACC_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      nbits_q <= '0;
      sgn_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      nbits_q <= nbits_d;
      sgn_q   <= sgn_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    nbits_d = nbits_q;
    sgn_d   = sgn_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          nbits_d = cfg_nbits;
          sgn_d   = cfg_signed;
        end
      end
      S_ACC: begin
        if (plane_acc) begin
          acc_d = sum;
          cnt_d = cnt_q + 5'd1;
          ovf_d = ovf_q | shift_ovf | add_ovf;
          if (last_plane) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    psum_ready = (state_q == S_ACC);
    out_valid  = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    acc_out    = acc_q;
    ovf        = ovf_q;
  end

endmodule
